// File: rtl/fib_stream_checker.sv
// Fibonacci term stream checker: validates seeds and recurrence,
// counts terms, captures the first mismatch and flags arithmetic wrap.
module fib_stream_checker #(
  parameter int unsigned       DATA_W      = 1024,
  parameter int unsigned       CNT_W       = 32,
  parameter logic [DATA_W-1:0] SEED0       = DATA_W'(1),
  parameter logic [DATA_W-1:0] SEED1       = DATA_W'(1),
  parameter bit                STOP_ON_ERR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic [CNT_W-1:0]  o_term_cnt,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_err_idx,
  output logic [DATA_W-1:0] o_exp_data,
  output logic [DATA_W-1:0] o_got_data,
  output logic              o_wrap
);

  typedef enum logic [1:0] {
    S_SEED0,
    S_SEED1,
    S_RUN,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] got_q, got_d;
  logic              wrap_q, wrap_d;
  logic              ready_q, ready_d;

  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] exp_w;
  logic              carry_w;
  logic              accept_w;
  logic              mism_w;

  assign sum_w    = {1'b0, a_q} + {1'b0, b_q};
  assign accept_w = i_valid & ready_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    got_d   = got_q;
    wrap_d  = wrap_q;
    exp_w   = '0;
    carry_w = 1'b0;

    unique case (state_q)
      S_SEED0: exp_w = SEED0;
      S_SEED1: exp_w = SEED1;
      S_RUN:   {carry_w, exp_w} = sum_w;
      S_HALT:  exp_w = '0;
    endcase

    mism_w = (i_data != exp_w);

    if (i_clear) begin
      state_d = S_SEED0;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      idx_d   = '0;
      exp_d   = '0;
      got_d   = '0;
      wrap_d  = 1'b0;
    end else if (accept_w) begin
      // History tracks received data so a single bad term resyncs
      b_d   = i_data;
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      unique case (state_q)
        S_SEED0: state_d = S_SEED1;
        S_SEED1: begin
          a_d     = b_q;
          state_d = S_RUN;
        end
        S_RUN: begin
          a_d    = b_q;
          wrap_d = wrap_q | carry_w;
        end
        S_HALT: state_d = S_HALT;
      endcase
      if (mism_w) begin
        if (!err_q) begin
          err_d = 1'b1;
          idx_d = cnt_q;
          exp_d = exp_w;
          got_d = i_data;
        end
        if (STOP_ON_ERR) state_d = S_HALT;
      end
    end

    ready_d = (state_d != S_HALT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_SEED0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      exp_q   <= '0;
      got_q   <= '0;
      wrap_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      got_q   <= got_d;
      wrap_q  <= wrap_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_term_cnt = cnt_q;
  assign o_err      = err_q;
  assign o_err_idx  = idx_q;
  assign o_exp_data = exp_q;
  assign o_got_data = got_q;
  assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_fib_stream_checker.sv
// Directed bench for fib_stream_checker: three instances cover
// 16-bit halt-on-error, 8-bit wrap/saturation, and 8-bit keep-checking.
module tb_fib_stream_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  // A: DATA_W=16, STOP_ON_ERR=1
  logic        clr_a, vld_a, rdy_a, err_a, wrap_a;
  logic [15:0] dat_a, exp_a, got_a;
  logic [31:0] cnt_a, idx_a;
  // B: DATA_W=8, CNT_W=4, STOP_ON_ERR=1
  logic        clr_b, vld_b, rdy_b, err_b, wrap_b;
  logic [7:0]  dat_b, exp_b, got_b;
  logic [3:0]  cnt_b, idx_b;
  // C: DATA_W=8, STOP_ON_ERR=0
  logic        clr_c, vld_c, rdy_c, err_c, wrap_c;
  logic [7:0]  dat_c, exp_c, got_c;
  logic [31:0] cnt_c, idx_c;

  fib_stream_checker #(.DATA_W(16), .STOP_ON_ERR(1'b1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_a),
    .i_valid(vld_a), .o_ready(rdy_a), .i_data(dat_a),
    .o_term_cnt(cnt_a), .o_err(err_a), .o_err_idx(idx_a),
    .o_exp_data(exp_a), .o_got_data(got_a), .o_wrap(wrap_a)
  );

  fib_stream_checker #(.DATA_W(8), .CNT_W(4), .STOP_ON_ERR(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_b),
    .i_valid(vld_b), .o_ready(rdy_b), .i_data(dat_b),
    .o_term_cnt(cnt_b), .o_err(err_b), .o_err_idx(idx_b),
    .o_exp_data(exp_b), .o_got_data(got_b), .o_wrap(wrap_b)
  );

  fib_stream_checker #(.DATA_W(8), .STOP_ON_ERR(1'b0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_c),
    .i_valid(vld_c), .o_ready(rdy_c), .i_data(dat_c),
    .o_term_cnt(cnt_c), .o_err(err_c), .o_err_idx(idx_c),
    .o_exp_data(exp_c), .o_got_data(got_c), .o_wrap(wrap_c)
  );

  task automatic send_a(input logic [15:0] d);
    @(negedge clk);
    vld_a = 1'b1;
    dat_a = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [7:0] d);
    @(negedge clk);
    vld_b = 1'b1;
    dat_b = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_c(input logic [7:0] d);
    @(negedge clk);
    vld_c = 1'b1;
    dat_c = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    @(negedge clk);
    vld_a = 1'b0;
    vld_b = 1'b0;
    vld_c = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic gap_a();
    int n;
    n = int'($urandom_range(2, 0));
    repeat (n) begin
      @(negedge clk);
      vld_a = 1'b0;
      dat_a = 16'hdead;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_a = 0; vld_a = 0; dat_a = '0;
    clr_b = 0; vld_b = 0; dat_b = '0;
    clr_c = 0; vld_c = 0; dat_c = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (rdy_a !== 1'b0) $display("FAIL rst_ready got %0b want 0", rdy_a);
    else pass_cnt++;
    total++;
    if (cnt_a !== 32'd0 || err_a !== 1'b0 || wrap_a !== 1'b0)
      $display("FAIL rst_status got cnt=%0d err=%0b wrap=%0b want 0/0/0",
               cnt_a, err_a, wrap_a);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || rdy_c !== 1'b1)
      $display("FAIL rst_release_ready got %0b%0b%0b want 111",
               rdy_a, rdy_b, rdy_c);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [15:0] seq [8] = '{1, 1, 2, 3, 5, 8, 13, 21};
    bit rdy_ok = 1'b1;
    foreach (seq[i]) begin
      send_a(seq[i]);
      if (rdy_a !== 1'b1) rdy_ok = 1'b0;
    end
    idle_all();
    total++;
    if (!rdy_ok) $display("FAIL basic_ready got dropped want held 1");
    else pass_cnt++;
    total++;
    if (cnt_a !== 32'd8) $display("FAIL basic_cnt got %0d want 8", cnt_a);
    else pass_cnt++;
    total++;
    if (err_a !== 1'b0 || wrap_a !== 1'b0)
      $display("FAIL basic_flags got err=%0b wrap=%0b want 0/0", err_a, wrap_a);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [7:0] seq [13] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    foreach (seq[i]) send_b(seq[i]);
    total++;
    if (wrap_b !== 1'b0) $display("FAIL wrap_early got %0b want 0", wrap_b);
    else pass_cnt++;
    send_b(8'd121);
    total++;
    if (wrap_b !== 1'b1) $display("FAIL wrap_set got %0b want 1", wrap_b);
    else pass_cnt++;
    total++;
    if (err_b !== 1'b0 || cnt_b !== 4'd14)
      $display("FAIL wrap_status got err=%0b cnt=%0d want 0/14", err_b, cnt_b);
    else pass_cnt++;
    send_b(8'd98);
    send_b(8'd219);
    idle_all();
    total++;
    if (cnt_b !== 4'd15 || err_b !== 1'b0)
      $display("FAIL cnt_saturate got cnt=%0d err=%0b want 15/0", cnt_b, err_b);
    else pass_cnt++;
  endtask

  task automatic test_stop_on_err();
    @(negedge clk);
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    clr_a = 1'b0;
    total++;
    if (cnt_a !== 32'd0) $display("FAIL stop_clear got %0d want 0", cnt_a);
    else pass_cnt++;
    send_a(16'd1);
    send_a(16'd1);
    send_a(16'd2);
    send_a(16'd4);
    total++;
    if (err_a !== 1'b1 || idx_a !== 32'd3)
      $display("FAIL stop_capture got err=%0b idx=%0d want 1/3", err_a, idx_a);
    else pass_cnt++;
    total++;
    if (exp_a !== 16'd3 || got_a !== 16'd4)
      $display("FAIL stop_data got exp=%0d got=%0d want 3/4", exp_a, got_a);
    else pass_cnt++;
    total++;
    if (rdy_a !== 1'b0) $display("FAIL stop_ready got %0b want 0", rdy_a);
    else pass_cnt++;
    @(negedge clk);
    vld_a = 1'b1;
    dat_a = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cnt_a !== 32'd4 || rdy_a !== 1'b0)
      $display("FAIL stop_hold got cnt=%0d rdy=%0b want 4/0", cnt_a, rdy_a);
    else pass_cnt++;
    idle_all();
  endtask

  task automatic test_keep_checking();
    logic [7:0] seq [7] = '{1, 1, 2, 4, 6, 10, 9};
    foreach (seq[i]) send_c(seq[i]);
    idle_all();
    total++;
    if (err_c !== 1'b1 || idx_c !== 32'd3)
      $display("FAIL nostop_capture got err=%0b idx=%0d want 1/3", err_c, idx_c);
    else pass_cnt++;
    total++;
    if (exp_c !== 8'd3 || got_c !== 8'd4)
      $display("FAIL nostop_data got exp=%0d got=%0d want 3/4", exp_c, got_c);
    else pass_cnt++;
    total++;
    if (cnt_c !== 32'd7 || rdy_c !== 1'b1)
      $display("FAIL nostop_cnt got cnt=%0d rdy=%0b want 7/1", cnt_c, rdy_c);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    logic [15:0] seq [5] = '{1, 1, 2, 3, 5};
    @(negedge clk);
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    clr_a = 1'b0;
    total++;
    if (rdy_a !== 1'b1 || err_a !== 1'b0 || cnt_a !== 32'd0)
      $display("FAIL clear_halt got rdy=%0b err=%0b cnt=%0d want 1/0/0",
               rdy_a, err_a, cnt_a);
    else pass_cnt++;
    foreach (seq[i]) begin
      gap_a();
      send_a(seq[i]);
    end
    gap_a();
    total++;
    if (cnt_a !== 32'd5 || err_a !== 1'b0)
      $display("FAIL gaps_cnt got cnt=%0d err=%0b want 5/0", cnt_a, err_a);
    else pass_cnt++;
    @(negedge clk);
    vld_a = 1'b1;
    dat_a = 16'd8;
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    clr_a = 1'b0;
    vld_a = 1'b0;
    total++;
    if (cnt_a !== 32'd0 || err_a !== 1'b0 || wrap_a !== 1'b0 ||
        idx_a !== 32'd0 || exp_a !== 16'd0 || got_a !== 16'd0)
      $display("FAIL clear_accept got cnt=%0d err=%0b wrap=%0b idx=%0d exp=%0d got=%0d want all 0",
               cnt_a, err_a, wrap_a, idx_a, exp_a, got_a);
    else pass_cnt++;
    send_a(16'd1);
    send_a(16'd1);
    send_a(16'd2);
    idle_all();
    total++;
    if (cnt_a !== 32'd3 || err_a !== 1'b0)
      $display("FAIL clear_reseed got cnt=%0d err=%0b want 3/0", cnt_a, err_a);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    send_a(16'd3);
    send_a(16'd5);
    idle_all();
    total++;
    if (cnt_a !== 32'd5 || err_a !== 1'b0)
      $display("FAIL pre_rst got cnt=%0d err=%0b want 5/0", cnt_a, err_a);
    else pass_cnt++;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (cnt_a !== 32'd0 || rdy_a !== 1'b0)
      $display("FAIL async_rst_a got cnt=%0d rdy=%0b want 0/0", cnt_a, rdy_a);
    else pass_cnt++;
    total++;
    if (wrap_b !== 1'b0 || err_c !== 1'b0 || exp_c !== 8'd0 || cnt_c !== 32'd0)
      $display("FAIL async_rst_bc got wrap=%0b err=%0b exp=%0d cnt=%0d want 0/0/0/0",
               wrap_b, err_c, exp_c, cnt_c);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    send_a(16'd1);
    send_a(16'd1);
    send_a(16'd2);
    idle_all();
    total++;
    if (cnt_a !== 32'd3 || err_a !== 1'b0 || rdy_a !== 1'b1)
      $display("FAIL post_rst got cnt=%0d err=%0b rdy=%0b want 3/0/1",
               cnt_a, err_a, rdy_a);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stop_on_err();
    test_keep_checking();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
